// File: rtl/rr_packet_mux_arbiter.sv
// rtl/rr_packet_mux_arbiter.sv - round-robin packet arbiter steering an N:1 mux into one registered output
module rr_packet_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   in_valid_i,
  input  logic [N-1:0]   in_last_i,
  input  logic [N*W-1:0] in_data_i,
  output logic [N-1:0]   in_ready_o,
  output logic           out_valid_o,
  output logic           out_last_o,
  output logic [W-1:0]   out_data_o,
  output logic [IDW-1:0] out_id_o,
  input  logic           out_ready_i
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;

  logic           out_valid_q;
  logic           out_last_q;
  logic [W-1:0]   out_data_q;
  logic [IDW-1:0] out_id_q;

  logic           load;
  logic           cand_found;
  logic [IDW-1:0] cand_idx;
  logic [IDW-1:0] probe;
  logic           grant_en;
  logic [IDW-1:0] grant_idx;
  logic           xfer;
  logic           sel_last;
  logic [W-1:0]   sel_data;

  // Modulo-N increment; N need not be a power of two.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (int'(idx) == N - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  assign load = !out_valid_q || out_ready_i;

  // First valid requester scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = ptr_q;
    probe      = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!cand_found && in_valid_i[probe]) begin
        cand_found = 1'b1;
        cand_idx   = probe;
      end
      probe = wrap_inc(probe);
    end
  end

  // A locked owner keeps the grant even across bubbles in its packet.
  always_comb begin
    if (state_q == S_LOCKED) begin
      grant_en  = 1'b1;
      grant_idx = owner_q;
    end else begin
      grant_en  = cand_found;
      grant_idx = cand_idx;
    end
  end

  assign xfer     = !rst_i && grant_en && load && in_valid_i[grant_idx];
  assign sel_last = in_last_i[grant_idx];
  assign sel_data = in_data_i[int'(grant_idx)*W +: W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      if (sel_last) begin
        state_d = S_IDLE;
        ptr_d   = wrap_inc(grant_idx);
      end else begin
        state_d = S_LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  always_comb begin
    in_ready_o = '0;
    if (!rst_i && grant_en && load) begin
      in_ready_o[grant_idx] = 1'b1;
    end
  end

  // Output stage: stalls entirely while a word is held and not accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_last_q  <= sel_last;
        out_data_q  <= sel_data;
        out_id_q    <= grant_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;

endmodule
